// File: rtl/ext_bus_pkg.sv
// ext_bus_sequencer shared types and constants.
// Byte-serial bus phases, pad widths and CMD byte layout.
package ext_bus_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int PAD_W          = 8;

  localparam int CMD_WE    = 0;
  localparam int CMD_GRANT = 1;

  localparam logic [PAD_W-1:0] OE_DRIVE   = 8'hFF;
  localparam logic [PAD_W-1:0] OE_RELEASE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CMD,
    DATA,
    DONE
  } state_e;

  function automatic logic [PAD_W-1:0] word_byte(
    input logic [31:0] w,
    input logic [1:0]  k
  );
    return w[{k, 3'b000} +: PAD_W];
  endfunction

endpackage

// File: rtl/ext_bus_if.sv
// Requester handshake and pad lanes of the external bus sequencer.
// slave = sequencer side, master = core/pad side.
interface ext_bus_if;

  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;

  logic [31:0] rdata;
  logic        busy;

  logic [7:0]  pad_out;
  logic [7:0]  pad_io_out;
  logic [7:0]  pad_io_in;
  logic [7:0]  pad_io_oe;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  pad_io_in,
    output m0_ack, m1_ack, rdata, busy,
    output pad_out, pad_io_out, pad_io_oe
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output pad_io_in,
    input  m0_ack, m1_ack, rdata, busy,
    input  pad_out, pad_io_out, pad_io_oe
  );

endinterface

// File: rtl/ext_bus_sequencer_arb.sv
// Two-requester round-robin arbiter.
// last_q starts at 1 so port 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_id_o,
  output logic       any_o
);

  logic last_q, last_d;

  always_comb begin
    any_o = |req_i;
    if (req_i == 2'b11) gnt_id_o = ~last_q;
    else                gnt_id_o = req_i[1];
    last_d = upd_i ? gnt_id_o : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/ext_bus_sequencer.sv
// Byte-serial external bus sequencer with two-port round-robin grant.
// Outputs are registered from next-state values for fixed 10-cycle latency.
module ext_bus_sequencer
  import ext_bus_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  ext_bus_if.slave bus
);

  localparam logic [1:0] LAST_PH = 2'(BYTES_PER_WORD - 1);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             we_q, we_d;
  logic             gid_q, gid_d;
  logic [PAD_W-1:0] pad_q, pad_d;
  logic [PAD_W-1:0] io_q, io_d;
  logic [PAD_W-1:0] oe_q, oe_d;
  logic [1:0]       ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             any_req, gnt_id, grant;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({bus.m1_req, bus.m0_req}),
    .upd_i    (grant),
    .gnt_id_o (gnt_id),
    .any_o    (any_req)
  );

  assign grant = (state_q == IDLE) && any_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: if (any_req) begin
        state_d = ADDR;
        phase_d = '0;
      end
      ADDR: if (phase_q == LAST_PH) begin
        state_d = CMD;
        phase_d = '0;
      end else begin
        phase_d = phase_q + 2'd1;
      end
      CMD: begin
        state_d = DATA;
        phase_d = '0;
      end
      DATA: if (phase_q == LAST_PH) begin
        state_d = DONE;
        phase_d = '0;
      end else begin
        phase_d = phase_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transfer context latched on the grant edge; read bytes land LSB first
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    gid_d   = gid_q;
    rdata_d = rdata_q;
    if (grant) begin
      gid_d   = gnt_id;
      we_d    = gnt_id ? bus.m1_we    : bus.m0_we;
      addr_d  = gnt_id ? bus.m1_addr  : bus.m0_addr;
      wdata_d = gnt_id ? bus.m1_wdata : bus.m0_wdata;
    end
    if (state_q == DATA && !we_q)
      rdata_d[{phase_q, 3'b000} +: PAD_W] = bus.pad_io_in;
  end

  always_comb begin
    pad_d  = '0;
    io_d   = '0;
    oe_d   = OE_RELEASE;
    ack_d  = '0;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      ADDR: begin
        pad_d = word_byte(addr_d, phase_d);
        oe_d  = OE_DRIVE;
        io_d  = we_d ? word_byte(wdata_d, phase_d) : '0;
      end
      CMD: begin
        pad_d[CMD_WE]    = we_d;
        pad_d[CMD_GRANT] = gid_d;
      end
      DATA: if (we_d) begin
        oe_d = OE_DRIVE;
        io_d = word_byte(wdata_d, phase_d);
      end
      DONE:    ack_d[gid_d] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      gid_q   <= 1'b0;
      rdata_q <= '0;
      pad_q   <= '0;
      io_q    <= '0;
      oe_q    <= OE_RELEASE;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      gid_q   <= gid_d;
      rdata_q <= rdata_d;
      pad_q   <= pad_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.m0_ack     = ack_q[0];
  assign bus.m1_ack     = ack_q[1];
  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.pad_out    = pad_q;
  assign bus.pad_io_out = io_q;
  assign bus.pad_io_oe  = oe_q;

endmodule
